// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RISC-V control FSM
// Sequences fetch/decode/execute/memory/writeback and drives datapath selects and enables.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] imm_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_HALT
  } state_t;

  state_t state, next_state;
  logic   pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic   unused_funct3;

  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && next_state == S_HALT)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    aluop       = 2'b00;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_JAL:       next_state = S_JAL;
          OP_BR:        next_state = S_BRANCH;
          default:      next_state = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = 2'b10;
        aluop      = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        aluop      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write_c = 1'b1;
        next_state = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        aluop      = 2'b01;
        pc_write_c = zero ^ funct3[0];
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Enables drop the instant reset asserts, independent of the state register.
  assign pc_write  = pc_write_c  & reset_n;
  assign mem_write = mem_write_c & reset_n;
  assign ir_write  = ir_write_c  & reset_n;
  assign reg_write = reg_write_c & reset_n;

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BR:   imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
// Per-cycle expectations come from instruction step lists and a table of per-step outputs.
module tb_mc_controller;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, aluop, imm_src;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

  logic [15:0] expq[$];
  string       nameq[$];
  int          total = 0;
  int          bad = 0;
  bit          model_ill = 1'b0;

  // Vector layout: pc_write adr_src mem_write ir_write reg_write result_src alu_src_a alu_src_b aluop imm_src illegal
  function automatic logic [15:0] expect_vec(input string st, input logic [6:0] o,
      input logic [2:0] f3, input logic z, input logic mr, input logic rn, input logic il);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, ao, is;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 0; sa = 0; sb = 0; ao = 0;
    if (o == SW) is = 2'd1;
    else if (o == BR) is = 2'd2;
    else if (o == JL) is = 2'd3;
    else is = 2'd0;
    case (st)
      "FETCH":    begin sb = 2; rs = 2; irw = mr; pcw = mr; end
      "DECODE":   begin sa = 1; sb = 1; end
      "MEMADR":   begin sa = 2; sb = 1; end
      "MEMREAD":  begin adr = 1; end
      "MEMWB":    begin rs = 1; rw = 1; end
      "MEMWRITE": begin adr = 1; mw = 1; end
      "EXECR":    begin sa = 2; ao = 2; end
      "EXECI":    begin sa = 2; sb = 1; ao = 2; end
      "ALUWB":    begin rw = 1; end
      "JAL":      begin sa = 1; sb = 2; pcw = 1; end
      "BRANCH":   begin sa = 2; ao = 1; pcw = (z != f3[0]); end
      default:    ;
    endcase
    if (!rn) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, is, il};
  endfunction

  task automatic cycle(input string st, input logic mr, input logic z, input logic rn);
    mem_ready = mr;
    zero = z;
    reset_n = rn;
    expq.push_back(expect_vec(st, op, funct3, z, mr, rn, model_ill));
    nameq.push_back(st);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    model_ill = 1'b0;
    for (int i = 0; i < n; i++) cycle("FETCH", 1'b1, 1'($urandom), 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic fetch_decode();
    int w;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) cycle("FETCH", 1'b0, 1'($urandom), 1'b1);
    cycle("FETCH", 1'b1, 1'($urandom), 1'b1);
    cycle("DECODE", 1'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input int rd_waits);
    op = o;
    funct3 = f3;
    fetch_decode();
    case (o)
      LW: begin
        cycle("MEMADR", 1'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < rd_waits; i++) cycle("MEMREAD", 1'b0, 1'($urandom), 1'b1);
        cycle("MEMREAD", 1'b1, 1'($urandom), 1'b1);
        cycle("MEMWB", 1'($urandom), 1'($urandom), 1'b1);
      end
      SW: begin
        cycle("MEMADR", 1'($urandom), 1'($urandom), 1'b1);
        cycle("MEMWRITE", 1'($urandom), 1'($urandom), 1'b1);
      end
      RT: begin
        cycle("EXECR", 1'($urandom), 1'($urandom), 1'b1);
        cycle("ALUWB", 1'($urandom), 1'($urandom), 1'b1);
      end
      IT: begin
        cycle("EXECI", 1'($urandom), 1'($urandom), 1'b1);
        cycle("ALUWB", 1'($urandom), 1'($urandom), 1'b1);
      end
      JL: begin
        cycle("JAL", 1'($urandom), 1'($urandom), 1'b1);
        cycle("ALUWB", 1'($urandom), 1'($urandom), 1'b1);
      end
      BR: cycle("BRANCH", 1'($urandom), 1'($urandom), 1'b1);
      default: begin
        model_ill = 1'b1;
        for (int i = 0; i < 20; i++) cycle("HALT", 1'($urandom), 1'($urandom), 1'b1);
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [15:0] act, e;
    string nm;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      nm = nameq.pop_front();
      act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
             alu_src_a, alu_src_b, aluop, imm_src, illegal};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL step_%s op=%b f3=%b zero=%b mr=%b rst_n=%b actual=%b required=%b",
                 nm, op, funct3, zero, mem_ready, reset_n, act, e);
      end
    end
  end

  initial begin
    logic [6:0] legal_ops[6];
    legal_ops = '{LW, SW, RT, IT, JL, BR};
    @(posedge clk);
    #1;
    do_reset(3);
    do_instr(RT, 3'b000, 0);
    do_instr(LW, 3'b010, 2);
    for (int b = 0; b < 4; b++) begin
      op = BR;
      funct3 = {2'b00, 1'(b >> 1)};
      fetch_decode();
      cycle("BRANCH", 1'($urandom), 1'(b & 1), 1'b1);
    end
    do_instr(SW, 3'b010, 0);
    do_instr(JL, 3'b000, 0);
    do_instr(IT, 3'b000, 0);
    for (int k = 0; k < 40; k++)
      do_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom), $urandom_range(0, 3));
    do_instr(7'b1111111, 3'b000, 0);
    do_reset(2);
    do_instr(RT, 3'b000, 0);
    // Reset dropped while a store sits in MEMADR must suppress its write.
    op = SW;
    funct3 = 3'b010;
    fetch_decode();
    do_reset(2);
    do_instr(SW, 3'b010, 0);
    op = 7'b0001111;
    do_instr(7'b0001111, 3'b000, 0);
    do_reset(1);
    for (int k = 0; k < 20; k++)
      do_instr(legal_ops[$urandom_range(0, 5)], 3'($urandom), $urandom_range(0, 2));
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
